md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL take parameter MUL_CYCLES, default 5: busy cycles of a mult/multu after issue.
REQ-002 SHALL take parameter DIV_CYCLES, default 10: busy cycles of a div/divu after issue.
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have e_valid, input, 1: a mult/div-class instruction is in E this cycle.
REQ-006 SHALL have e_op, input, 3: 0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi; 6-7 are illegal.
REQ-007 SHALL have rs_val and rt_val, input, 32 each: forwarded E-stage operands.
REQ-008 SHALL have flush, input, 1: interrupt/exception flush of the E instruction.
REQ-009 SHALL have d_md_use, input, 1: the D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have busy_in, input, 1: busy from the multiply/divide unit.
REQ-011 SHALL have start, output, 1, and select, output, 5: issue controls to the unit.
REQ-012 SHALL have d1_out and d2_out, output, 32 each: operands to the unit.
REQ-013 SHALL have stall, output, 1: freeze the D stage.
REQ-014 SHALL have done, output, 1: a HI/LO write happens at the closing edge of this cycle.
REQ-015 SHALL have dz_flag, output, 1: sticky divide-by-zero seen.
REQ-016 SHALL have sync_err, output, 1: sticky disagreement between the shadow counter and busy_in.
REQ-017 SHALL have stall_cnt, output, 32: count of stall cycles.

Function
REQ-018 SHALL issue when e_valid=1, flush=0 and e_op<=3: start=1, select=e_op, d1_out=rs_val, d2_out=rt_val, combinationally in that cycle.
REQ-019 SHALL handle e_op 4 or 5 with e_valid=1 and flush=0 as follows: start=0, select=e_op, d1_out=rs_val.
REQ-020 SHALL, in every other cycle (including illegal e_op 6-7), drive start=0, select=5'd31, d1_out=0 and d2_out=0.
REQ-021 SHALL keep a shadow FSM with states IDLE, MUL and DIV and a 4-bit counter.
REQ-022 SHALL, on an issue of op 0/1, go to MUL with cnt=MUL_CYCLES; on op 2/3, go to DIV with cnt=DIV_CYCLES.
REQ-023 SHALL, in MUL/DIV, decrement cnt each cycle and return to IDLE when cnt goes 1->0.
REQ-024 SHALL drive done=1 exactly in the cycle where cnt==1, i.e. a single-cycle pulse per operation.
REQ-025 SHALL compute stall = d_md_use & (start | busy_in | state!=IDLE), combinationally.
REQ-026 SHALL not stall the E instruction itself; E only advances, so no issue can occur while the FSM is non-IDLE.
REQ-027 SHALL, if an issue is nonetheless requested while non-IDLE, restart the FSM with the new op (matching the unit's overwrite) and set sync_err.
REQ-028 SHALL suppress the issue when flush=1 in the same cycle as e_valid: start=0, select=31, FSM unchanged.
REQ-029 SHALL not cancel an operation already in MUL/DIV on flush; it completes and done still pulses.
REQ-030 SHALL set dz_flag on issue of op 2/3 with rt_val==0; it clears only on reset.
REQ-031 SHALL set sync_err in any cycle after an issue where (state!=IDLE) != busy_in.
REQ-032 SHALL increment stall_cnt in every cycle with stall=1, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-033 SHALL, while reset=1 (asynchronous), force state=IDLE, cnt=0, dz_flag=0, sync_err=0 and stall_cnt=0.
REQ-034 SHALL, while reset=1, also force start=0, select=31, d1_out=0, d2_out=0, done=0 and stall=0.
REQ-035 SHALL abandon any operation on reset mid-operation and sit in IDLE on the first edge after release.

Structure
REQ-036 SHALL take the op encodings 0-5, the idle select value 31 and the FSM state encodings from the shared mdu package.
REQ-037 SHALL have MUL_CYCLES and DIV_CYCLES match the unit's latencies via the same package constants.
REQ-038 SHALL use one sub-module, md_shadow_cnt (FSM plus counter plus done); decode and stall logic stay in the top.

Verification
REQ-039 SHALL cover mult: e_op=0, rs=3, rt=-2 -> start=1/select=0 for one cycle, done in cycle 5 after issue, FSM IDLE at cycle 6.
REQ-040 SHALL cover divu: e_op=3, rt=0 -> dz_flag=1, busy 10 cycles, and d_md_use held 1 -> stall=1 for 11 cycles with stall_cnt=11.
REQ-041 SHALL cover mthi during a mult: mthi in D while MUL -> stall until IDLE; then select=5, start=0, d1_out=rs_val.
REQ-042 SHALL cover flush: flush=1 with e_valid=1, e_op=2 -> start=0, select=31, FSM stays IDLE, dz_flag unchanged.
REQ-043 SHALL cover reset mid-div: assert reset at cnt=6 -> all outputs at reset values immediately; after release, no done pulse appears.
REQ-044 SHALL cover a busy mismatch: hold busy_in=0 while the FSM is in MUL -> sync_err=1 and it stays set until reset.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared multiply/divide constants: op encodings, idle select,
// unit latencies and shadow FSM state encodings.
package md_issue_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;

    localparam logic [4:0] SEL_IDLE = 5'd31;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_shadow_cnt.sv
// Shadow of the multiply/divide unit: tracks MUL/DIV occupancy
// with a down-counter and pulses done on the last busy cycle.
module md_shadow_cnt
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [2:0] op,
    output logic       active,
    output logic       done
);

    logic [1:0] state;
    logic [3:0] cnt;

    // A new issue always wins, even mid-operation, mirroring the unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else if (issue) begin
            if (is_div_op(op)) begin
                state <= ST_DIV;
                cnt   <= 4'(DIV_CYCLES);
            end else begin
                state <= ST_MUL;
                cnt   <= 4'(MUL_CYCLES);
            end
        end else if (state != ST_IDLE) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                state <= ST_IDLE;
            end
        end
    end

    assign active = (state != ST_IDLE);
    assign done   = active && (cnt == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue decode for the multiply/divide unit, D-stage stall
// generation and sticky status (divide-by-zero, shadow desync).
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        d_md_use,
    input  logic        busy_in,
    output logic        start,
    output logic [4:0]  select,
    output logic [31:0] d1_out,
    output logic [31:0] d2_out,
    output logic        stall,
    output logic        done,
    output logic        dz_flag,
    output logic        sync_err,
    output logic [31:0] stall_cnt
);

    logic e_live;
    logic issue;
    logic move;
    logic active;
    logic armed;

    // Reset gates the combinational outputs as well as the flops.
    assign e_live = e_valid & ~flush & ~reset;
    assign issue  = e_live & (is_mul_op(e_op) | is_div_op(e_op));
    assign move   = e_live & ((e_op == OP_MTLO) | (e_op == OP_MTHI));

    always_comb begin
        start  = 1'b0;
        select = SEL_IDLE;
        d1_out = 32'd0;
        d2_out = 32'd0;
        if (issue) begin
            start  = 1'b1;
            select = {2'b00, e_op};
            d1_out = rs_val;
            d2_out = rt_val;
        end else if (move) begin
            select = {2'b00, e_op};
            d1_out = rs_val;
        end
    end

    md_shadow_cnt #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_shadow (
        .clk    (clk),
        .reset  (reset),
        .issue  (issue),
        .op     (e_op),
        .active (active),
        .done   (done)
    );

    assign stall = ~reset & d_md_use & (start | busy_in | active);

    // armed: busy_in is only meaningful once the unit has seen an issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            dz_flag   <= 1'b0;
            sync_err  <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            if (issue) begin
                armed <= 1'b1;
            end
            if (issue && is_div_op(e_op) && (rt_val == 32'd0)) begin
                dz_flag <= 1'b1;
            end
            if ((issue && active) || (armed && (active != busy_in))) begin
                sync_err <= 1'b1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: expected done cycles are queued
// at issue and matched against done pulses; a unit model drives busy_in.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        d_md_use;
    logic        busy_in;
    logic        start;
    logic [4:0]  select;
    logic [31:0] d1_out;
    logic [31:0] d2_out;
    logic        stall;
    logic        done;
    logic        dz_flag;
    logic        sync_err;
    logic [31:0] stall_cnt;

    int checks;
    int errors;
    int unsigned cyc;
    int unsigned sb_q[$];
    int unsigned ucnt;
    logic force_low;
    int done_seen;

    md_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .d_md_use  (d_md_use),
        .busy_in   (busy_in),
        .start     (start),
        .select    (select),
        .d1_out    (d1_out),
        .d2_out    (d2_out),
        .stall     (stall),
        .done      (done),
        .dz_flag   (dz_flag),
        .sync_err  (sync_err),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Unit model: busy for the op latency starting the cycle after start.
    always @(posedge clk or posedge reset) begin
        if (reset) ucnt <= 0;
        else if (start) ucnt <= (select >= 5'd2) ? DIV_LAT : MUL_LAT;
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign busy_in = (ucnt != 0) && !force_low;

    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (sb_q.size() != 0) check("done_cyc", cyc, sb_q.pop_front());
            else check("done_extra", {31'd0, done}, 32'd0);
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl);
        e_valid = 1'b1;
        e_op    = op;
        rs_val  = rs;
        rt_val  = rt;
        flush   = fl;
        if (!fl && op <= 3'd1) sb_q.push_back(cyc + MUL_LAT);
        else if (!fl && op <= 3'd3) sb_q.push_back(cyc + DIV_LAT);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; done_seen = 0;
        reset = 1'b1; e_valid = 1'b0; e_op = 3'd0; rs_val = 0;
        rt_val = 0; flush = 1'b0; d_md_use = 1'b1; force_low = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        check("rst_start", {31'd0, start}, 0);
        check("rst_select", {27'd0, select}, 31);
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_dz", {31'd0, dz_flag}, 0);
        check("rst_sync", {31'd0, sync_err}, 0);
        check("rst_scnt", stall_cnt, 0);
        next_cyc();
        reset = 1'b0;
        d_md_use = 1'b0;
        next_cyc();

        // mult 3 * -2
        drive(3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        check("mul_start", {31'd0, start}, 1);
        check("mul_select", {27'd0, select}, 0);
        check("mul_d1", d1_out, 32'd3);
        check("mul_d2", d2_out, 32'hFFFF_FFFE);
        next_cyc();
        e_valid = 1'b0;
        @(negedge clk);
        check("mul_start1", {31'd0, start}, 0);
        check("mul_sel1", {27'd0, select}, 31);
        for (int i = 0; i < 5; i++) next_cyc();
        d_md_use = 1'b1;
        @(negedge clk);
        check("mul_idle6", {31'd0, stall}, 0);
        check("mul_sb", sb_q.size(), 0);
        d_md_use = 1'b0;
        next_cyc();

        // flushed div with rt=0
        drive(3'd2, 32'd9, 32'd0, 1'b1);
        @(negedge clk);
        check("fl_start", {31'd0, start}, 0);
        check("fl_select", {27'd0, select}, 31);
        check("fl_d1", d1_out, 0);
        next_cyc();
        e_valid = 1'b0; flush = 1'b0; d_md_use = 1'b1;
        @(negedge clk);
        check("fl_idle", {31'd0, stall}, 0);
        check("fl_dz", {31'd0, dz_flag}, 0);
        d_md_use = 1'b0;
        next_cyc();

        // divu by zero with D held
        d_md_use = 1'b1;
        drive(3'd3, 32'd100, 32'd0, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stall) n++;
            next_cyc();
            e_valid = 1'b0;
        end
        check("dv_stalls", n, 11);
        check("dv_scnt", stall_cnt, 11);
        check("dv_dz", {31'd0, dz_flag}, 1);
        d_md_use = 1'b0;

        // multu with mthi waiting in D
        d_md_use = 1'b1;
        drive(3'd1, 32'd7, 32'd9, 1'b0);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (stall) n++;
            if (i == 6) check("mth_free", {31'd0, stall}, 0);
            next_cyc();
            e_valid = 1'b0;
        end
        check("mth_stalls", n, 6);
        d_md_use = 1'b0;
        drive(3'd5, 32'h1234, 32'h55, 1'b0);
        @(negedge clk);
        check("mth_sel", {27'd0, select}, 5);
        check("mth_start", {31'd0, start}, 0);
        check("mth_d1", d1_out, 32'h1234);
        next_cyc();
        drive(3'd4, 32'hABCD, 32'h1, 1'b0);
        @(negedge clk);
        check("mtl_sel", {27'd0, select}, 4);
        check("mtl_d1", d1_out, 32'hABCD);
        next_cyc();
        drive(3'd6, 32'h77, 32'h1, 1'b0);
        @(negedge clk);
        check("ill_sel", {27'd0, select}, 31);
        check("ill_d1", d1_out, 0);
        check("ill_start", {31'd0, start}, 0);
        next_cyc();
        e_valid = 1'b0;
        next_cyc();
        check("pre_sync", {31'd0, sync_err}, 0);

        // busy_in stuck low during a mult
        force_low = 1'b1;
        drive(3'd0, 32'd2, 32'd2, 1'b0);
        next_cyc();
        e_valid = 1'b0;
        next_cyc();
        @(negedge clk);
        check("sy_set", {31'd0, sync_err}, 1);
        for (int i = 0; i < 6; i++) next_cyc();
        @(negedge clk);
        check("sy_hold", {31'd0, sync_err}, 1);
        force_low = 1'b0;
        next_cyc();

        // reset in the middle of a div
        drive(3'd2, 32'd50, 32'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            e_valid = 1'b0;
        end
        reset = 1'b1;
        e_valid = 1'b1; e_op = 3'd0; d_md_use = 1'b1;
        sb_q.delete();
        #1;
        check("mr_start", {31'd0, start}, 0);
        check("mr_select", {27'd0, select}, 31);
        check("mr_d1", d1_out, 0);
        check("mr_stall", {31'd0, stall}, 0);
        check("mr_done", {31'd0, done}, 0);
        check("mr_scnt", stall_cnt, 0);
        check("mr_sync", {31'd0, sync_err}, 0);
        check("mr_dz", {31'd0, dz_flag}, 0);
        next_cyc();
        next_cyc();
        reset = 1'b0;
        e_valid = 1'b0;
        done_seen = 0;
        @(negedge clk);
        check("mr_idle", {31'd0, stall}, 0);
        for (int i = 0; i < 14; i++) next_cyc();
        check("mr_nodone", done_seen, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
